multicycle_control_fsm: RTL and testbench
=========================================

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: number of consecutive MemReady=0 wait cycles that triggers FAULT; 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port OpCode  input  6  instruction[31:26] from IR; valid from DECODE onward.
REQ-005 SHALL have port MemReady  input  1  memory completion handshake for the current access.
REQ-006 SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA  output  1 each  standard multicycle datapath strobes and selects.
REQ-007 SHALL have ports RegDst, MemToReg, ALUSrcB, ALUOp, PCSource  output  2 each. Encodings:
- RegDst: 00 rt, 01 rd, 10 $31.
- MemToReg: 00 ALUOut, 01 MDR, 10 PC.
- ALUSrcB: 00 B, 01 const 4, 10 signext imm, 11 signext imm<<2.
- PCSource: 00 ALU, 01 ALUOut, 10 jump target.
REQ-008 SHALL have port State  output  4  current state code, for debug.
REQ-009 SHALL have ports InstrDone, Illegal, Fault  output  1 each.
- InstrDone: last cycle of an instruction.
- Illegal: unsupported opcode decoded.
- Fault: sticky memory timeout.

Function
REQ-010 State codes SHALL be:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
- EXECR=6, RWB=7, EXECI=8, IWB=9, BRANCH=10, JUMP=11, JAL=12, FAULT=15.
- Codes 13 and 14 SHALL go to FETCH on the next cycle.
REQ-011 Outputs SHALL be combinational from State, OpCode and MemReady; any output not listed for a state SHALL be 0.
REQ-012 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=MemReady. Stay while MemReady=0; go to DECODE when MemReady=1.
REQ-013 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by OpCode:
- 000000 -> EXECR.
- 100011 or 101011 -> MEMADR.
- 000100 -> BRANCH.
- 000010 -> JUMP.
- 000011 -> JAL.
- 001111, 001101, 001000, 001001 -> EXECI.
- Any other opcode -> FETCH, with Illegal=1 for that DECODE cycle only.
REQ-014 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if OpCode=100011, else MEMWR.
REQ-015 MEMRD: MemRead=1, IorD=1. Wait for MemReady, then go to MEMWB. MEMWB: RegWrite=1, MemToReg=01, RegDst=00, then FETCH.
REQ-016 MEMWR: MemWrite=1, IorD=1. Wait for MemReady, then go to FETCH.
REQ-017 EXECR: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then RWB. RWB: RegWrite=1, RegDst=01, MemToReg=00, then FETCH.
REQ-018 EXECI: ALUSrcA=1, ALUSrcB=10; ALUOp=11 for opcodes 001111/001101, else 00; then IWB. IWB: RegWrite=1, RegDst=00, MemToReg=00, then FETCH.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then FETCH. The datapath ANDs PCWriteCond with Zero.
REQ-020 JUMP: PCWrite=1, PCSource=10, then FETCH. JAL: same as JUMP plus RegWrite=1, RegDst=10, MemToReg=10, then FETCH.
REQ-021 InstrDone SHALL be 1 in MEMWB, RWB, IWB, BRANCH, JUMP and JAL, and in MEMWR when MemReady=1; otherwise 0.
REQ-022 Every instruction SHALL take exactly 3 cycles with zero wait states, except LW (5), SW (4) and R/I-type (4). Each wait cycle adds exactly one cycle.
REQ-023 Wait counter behaviour:
- Cleared on every state change and whenever MemReady=1.
- Incremented on each FETCH/MEMRD/MEMWR cycle with MemReady=0.
- When the counter equals WAIT_MAX-1 and MemReady=0 with WAIT_MAX!=0, next state SHALL be FAULT.
- Counter width SHALL hold WAIT_MAX without wrap.
REQ-024 FAULT SHALL be absorbing until reset: Fault=1 and all strobes 0. MemReady arriving late SHALL be ignored.
REQ-025 MemReady in any non-wait state SHALL have no effect.

Reset
REQ-026 While rst_n=0 the block SHALL be in this state, immediately and asynchronously:
- State=FETCH, wait counter=0, Fault=0.
- PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, InstrDone and Illegal forced to 0.
- Other selects at their FETCH values.
REQ-027 After rst_n deasserts, the first rising edge SHALL evaluate FETCH normally. A reset mid-instruction, including a pending wait or FAULT, SHALL abandon the instruction with no further strobes.

Verification
REQ-028 LW, MemReady held 1 -> states 0,1,2,3,4,0. RegWrite=1 with MemToReg=01 only in cycle 5. InstrDone pulses once.
REQ-029 SW with MemReady=0 for 3 cycles in MEMWR -> MemWrite high 4 cycles; InstrDone only in the cycle MemReady=1. Total 7 cycles.
REQ-030 OpCode=111111 in DECODE -> Illegal=1 for one cycle, next State=0, no RegWrite/MemWrite/PCWriteCond.
REQ-031 WAIT_MAX=4, MemReady=0 in FETCH -> State=15 after the 4th wait cycle. Fault stays 1 with MemReady=1 applied, and clears only on rst_n=0.
REQ-032 JAL -> states 0,1,12. In cycle 3: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemToReg=10.
REQ-033 rst_n pulled low mid-MEMRD (asynchronous, between edges) -> State=0 and MemRead=0 immediately. After release, fetch resumes with MemRead=1.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Control FSM for a multicycle MIPS-style datapath with memory wait handshake,
// illegal-opcode flagging and a sticky memory-timeout fault state.
module multicycle_control_fsm #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OpCode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       InstrDone,
    output logic       Illegal,
    output logic       Fault
);

    localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_RWB    = 4'd7,
        S_EXECI  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_FAULT  = 4'd15
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               is_wait_state;
    logic               timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign is_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout = (WAIT_MAX != 0) && !MemReady && (wait_cnt_q == CNT_W'(WAIT_MAX - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : (timeout ? S_FAULT : S_FETCH);
            S_DECODE: begin
                case (OpCode)
                    6'b000000:                    state_d = S_EXECR;
                    6'b100011, 6'b101011:         state_d = S_MEMADR;
                    6'b000100:                    state_d = S_BRANCH;
                    6'b000010:                    state_d = S_JUMP;
                    6'b000011:                    state_d = S_JAL;
                    6'b001111, 6'b001101,
                    6'b001000, 6'b001001:         state_d = S_EXECI;
                    default:                      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (OpCode == 6'b100011) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = MemReady ? S_MEMWB : (timeout ? S_FAULT : S_MEMRD);
            S_MEMWR:  state_d = MemReady ? S_FETCH : (timeout ? S_FAULT : S_MEMWR);
            S_EXECR:  state_d = S_RWB;
            S_EXECI:  state_d = S_IWB;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Counter saturates so a disabled timeout can never wrap back to zero.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_d != state_q) || MemReady) begin
            wait_cnt_d = '0;
        end else if (is_wait_state && (wait_cnt_q != {CNT_W{1'b1}})) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        RegDst      = 2'b00;
        MemToReg    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        InstrDone   = 1'b0;
        Illegal     = 1'b0;
        Fault       = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                Illegal = (state_d == S_FETCH);
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                MemToReg  = 2'b01;
                InstrDone = 1'b1;
            end
            S_MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = MemReady;
            end
            S_EXECR: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite  = 1'b1;
                RegDst    = 2'b01;
                InstrDone = 1'b1;
            end
            S_EXECI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ((OpCode == 6'b001111) || (OpCode == 6'b001101)) ? 2'b11 : 2'b00;
            end
            S_IWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                InstrDone   = 1'b1;
            end
            S_JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                InstrDone = 1'b1;
            end
            S_JAL: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                RegWrite  = 1'b1;
                RegDst    = 2'b10;
                MemToReg  = 2'b10;
                InstrDone = 1'b1;
            end
            S_FAULT: Fault = 1'b1;
            default: ;
        endcase
        // Reset must silence strobes immediately, before the state flop settles on an edge.
        if (!rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            InstrDone   = 1'b0;
            Illegal     = 1'b0;
            Fault       = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed per-cycle vectors push
// expected state/outputs; a monitor pops and compares at the falling edge.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] OpCode = 6'd0;
    logic       MemReady = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] RegDst, MemToReg, ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;
    logic       InstrDone, Illegal, Fault;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_ADI = 6'b001000;
    localparam logic [5:0] OP_BAD = 6'b111111;

    multicycle_control_fsm #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .State(State), .InstrDone(InstrDone), .Illegal(Illegal),
        .Fault(Fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [20:0] b;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    event chk_ev;

    // Bundle: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,ALUSrcA,
    //          RegDst,MemToReg,ALUSrcB,ALUOp,PCSource,InstrDone,Illegal,Fault}
    wire [20:0] act_b = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                         RegDst, MemToReg, ALUSrcB, ALUOp, PCSource, InstrDone, Illegal, Fault};

    function automatic logic [20:0] exp_bundle(input logic [3:0] st, input logic [5:0] op,
                                                input logic mr, input logic rst_ok);
        logic pcw, pcwc, iord, mrd, mwr, irw, rw, asa, done, ill, flt;
        logic [1:0] rd, m2r, asb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, rw, asa, done, ill, flt} = '0;
        {rd, m2r, asb, aop, pcs} = '0;
        case (st)
            4'd0:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
            4'd1:  begin asb = 2'b11;
                         ill = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL,
                                            6'b001111, OP_ORI, OP_ADI, 6'b001001}); end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 2'b01; done = 1; end
            4'd5:  begin mwr = 1; iord = 1; done = mr; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 2'b01; done = 1; end
            4'd8:  begin asa = 1; asb = 2'b10; aop = (op == OP_ORI || op == 6'b001111) ? 2'b11 : 2'b00; end
            4'd9:  begin rw = 1; done = 1; end
            4'd10: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            4'd11: begin pcw = 1; pcs = 2'b10; done = 1; end
            4'd12: begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; done = 1; end
            4'd15: flt = 1;
            default: ;
        endcase
        if (!rst_ok) {pcw, pcwc, mrd, mwr, irw, rw, done, ill, flt} = '0;
        return {pcw, pcwc, iord, mrd, mwr, irw, rw, asa, rd, m2r, asb, aop, pcs, done, ill, flt};
    endfunction

    task automatic push(input string tag, input logic [3:0] st);
        exp_t e;
        e.st  = st;
        e.b   = exp_bundle(st, OpCode, MemReady, rst_n);
        e.tag = tag;
        q.push_back(e);
    endtask

    // Drive one cycle's inputs, log its expectation, advance to just after the next edge.
    task automatic row(input string tag, input logic [5:0] op, input logic mr, input logic [3:0] st);
        OpCode   = op;
        MemReady = mr;
        push(tag, st);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (State !== e.st || act_b !== e.b) begin
                    n_bad++;
                    $display("FAIL %s: got state=%0d outs=%h, want state=%0d outs=%h",
                             e.tag, State, act_b, e.st, e.b);
                end
            end
        end
    end

    initial begin : stim
        #2;
        push("reset_state", 4'd0);
        ->chk_ev;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        row("lw_fetch",  OP_LW, 1, 4'd0);
        row("lw_decode", OP_LW, 1, 4'd1);
        row("lw_memadr", OP_LW, 1, 4'd2);
        row("lw_memrd",  OP_LW, 1, 4'd3);
        row("lw_memwb",  OP_LW, 1, 4'd4);

        row("r_fetch_wait", OP_R, 0, 4'd0);
        row("r_fetch",      OP_R, 1, 4'd0);
        row("r_decode",     OP_R, 0, 4'd1);
        row("r_exec",       OP_R, 0, 4'd6);
        row("r_wb",         OP_R, 1, 4'd7);

        row("sw_fetch",  OP_SW, 1, 4'd0);
        row("sw_decode", OP_SW, 0, 4'd1);
        row("sw_memadr", OP_SW, 1, 4'd2);
        row("sw_wait1",  OP_SW, 0, 4'd5);
        row("sw_wait2",  OP_SW, 0, 4'd5);
        row("sw_wait3",  OP_SW, 0, 4'd5);
        row("sw_done",   OP_SW, 1, 4'd5);

        row("ill_fetch",  OP_BAD, 1, 4'd0);
        row("ill_decode", OP_BAD, 1, 4'd1);

        row("jal_fetch",  OP_JAL, 1, 4'd0);
        row("jal_decode", OP_JAL, 0, 4'd1);
        row("jal_exec",   OP_JAL, 0, 4'd12);

        row("ori_fetch",  OP_ORI, 1, 4'd0);
        row("ori_decode", OP_ORI, 1, 4'd1);
        row("ori_exec",   OP_ORI, 1, 4'd8);
        row("ori_wb",     OP_ORI, 0, 4'd9);

        row("addi_fetch",  OP_ADI, 1, 4'd0);
        row("addi_decode", OP_ADI, 1, 4'd1);
        row("addi_exec",   OP_ADI, 1, 4'd8);
        row("addi_wb",     OP_ADI, 1, 4'd9);

        row("beq_fetch",  OP_BEQ, 1, 4'd0);
        row("beq_decode", OP_BEQ, 1, 4'd1);
        row("beq_exec",   OP_BEQ, 0, 4'd10);

        row("j_fetch",  OP_J, 1, 4'd0);
        row("j_decode", OP_J, 1, 4'd1);
        row("j_exec",   OP_J, 1, 4'd11);

        row("lw2_fetch",  OP_LW, 1, 4'd0);
        row("lw2_decode", OP_LW, 1, 4'd1);
        row("lw2_memadr", OP_LW, 1, 4'd2);
        OpCode   = OP_LW;
        MemReady = 1'b0;
        push("lw2_memrd_wait", 4'd3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        push("async_rst_memrd", 4'd0);
        ->chk_ev;
        @(posedge clk);
        #1;
        push("rst_held", 4'd0);
        ->chk_ev;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        row("resume_wait1", OP_LW, 0, 4'd0);
        row("fetch_wait2",  OP_LW, 0, 4'd0);
        row("fetch_wait3",  OP_LW, 0, 4'd0);
        row("fetch_wait4",  OP_LW, 0, 4'd0);
        row("fault_entry",  OP_LW, 1, 4'd15);
        row("fault_sticky", OP_LW, 1, 4'd15);
        row("fault_hold",   OP_LW, 0, 4'd15);

        rst_n = 1'b0;
        #1;
        push("fault_cleared", 4'd0);
        ->chk_ev;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        row("post_fault_fetch",  OP_LW, 1, 4'd0);
        row("post_fault_decode", OP_LW, 1, 4'd1);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
